// File: rtl/nios_mem_pkg.sv
// Shared types and sizes for the Nios II on-chip RAM arbiter.
package nios_mem_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = 4;
   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DEPTH  = 33000;
   localparam int HOLD_W     = 4;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } mst_e;

endpackage

// File: rtl/nios_mem_rr_pick.sv
// Combinational winner select: round-robin with a bounded hold window.
module nios_mem_rr_pick
   import nios_mem_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic [1:0]        req,
   input  mst_e              last_grant,
   input  logic [HOLD_W-1:0] hold_cnt,
   output logic              gnt_vld,
   output mst_e              winner
);

   logic keep;

   always_comb begin
      // hold_cnt == 0 means nobody currently owns the port
      keep    = (hold_cnt != '0) && (32'(hold_cnt) < MAX_HOLD);
      gnt_vld = |req;
      winner  = M0;
      unique case (req)
         2'b01:   winner = M0;
         2'b10:   winner = M1;
         2'b11:   winner = keep ? last_grant : mst_e'(~last_grant);
         default: winner = M0;
      endcase
   end

endmodule

// File: rtl/nios_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip RAM.
module nios_mem_arbiter
   import nios_mem_pkg::*;
#(
   parameter int ADDR_W   = MEM_ADDR_W,
   parameter int DEPTH    = MEM_DEPTH,
   parameter int MAX_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [MEM_BE_W-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [MEM_DATA_W-1:0] m0_writedata,
   output logic                  m0_waitrequest,
   output logic [MEM_DATA_W-1:0] m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [MEM_BE_W-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [MEM_DATA_W-1:0] m1_writedata,
   output logic                  m1_waitrequest,
   output logic [MEM_DATA_W-1:0] m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [MEM_BE_W-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [MEM_DATA_W-1:0] mem_writedata,
   input  logic [MEM_DATA_W-1:0] mem_readdata,
   output logic                  oor_err
);

   mst_e              last_grant_q, last_grant_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   mst_e              rd_owner_q, rd_owner_d;
   logic              rd_oor_q, rd_oor_d;
   logic              oor_err_q, oor_err_d;

   logic        gnt_vld;
   mst_e        winner;
   logic        win_m1;
   logic        sel_rd;
   logic        sel_wr;
   logic        oor;
   logic [31:0] rdata;

   nios_mem_rr_pick #(
      .MAX_HOLD (MAX_HOLD)
   ) u_pick (
      .req        ({m1_read | m1_write, m0_read | m0_write}),
      .last_grant (last_grant_q),
      .hold_cnt   (hold_cnt_q),
      .gnt_vld    (gnt_vld),
      .winner     (winner)
   );

   always_comb begin
      win_m1         = gnt_vld && (winner == M1);
      mem_address    = win_m1 ? m1_address    : m0_address;
      mem_byteenable = win_m1 ? m1_byteenable : m0_byteenable;
      mem_writedata  = win_m1 ? m1_writedata  : m0_writedata;
      sel_wr         = win_m1 ? m1_write      : m0_write;
      sel_rd         = (win_m1 ? m1_read : m0_read) & ~sel_wr;
      oor            = 32'(mem_address) >= DEPTH;
      mem_chipselect = gnt_vld & ~oor;
      mem_write      = gnt_vld & sel_wr & ~oor;
      m0_waitrequest = ~(gnt_vld && (winner == M0));
      m1_waitrequest = ~win_m1;
   end

   always_comb begin
      last_grant_d = gnt_vld ? winner : last_grant_q;
      hold_cnt_d   = '0;
      if (gnt_vld) begin
         if (winner != last_grant_q)
            hold_cnt_d = 4'd1;
         else if (hold_cnt_q == '1)
            hold_cnt_d = hold_cnt_q;
         else
            hold_cnt_d = hold_cnt_q + 4'd1;
      end
      rd_pend_d  = gnt_vld & sel_rd;
      rd_owner_d = gnt_vld ? winner : rd_owner_q;
      rd_oor_d   = oor;
      oor_err_d  = oor_err_q | (gnt_vld & oor);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= M1;
         hold_cnt_q   <= '0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= M0;
         rd_oor_q     <= 1'b0;
         oor_err_q    <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
         rd_oor_q     <= rd_oor_d;
         oor_err_q    <= oor_err_d;
      end
   end

   // out-of-range reads never touched the RAM, so return zero
   always_comb begin
      rdata            = rd_oor_q ? '0 : mem_readdata;
      m0_readdatavalid = rd_pend_q && (rd_owner_q == M0);
      m1_readdatavalid = rd_pend_q && (rd_owner_q == M1);
      m0_readdata      = m0_readdatavalid ? rdata : '0;
      m1_readdata      = m1_readdatavalid ? rdata : '0;
      oor_err          = oor_err_q;
   end

endmodule

// File: doc/nios_mem_arbiter.md
Name: nios_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares the single-port 32-bit on-chip RAM between the Nios II data master (m0) and a secondary master such as DMA or a video reader (m1).
- Grants one transfer per cycle using round-robin with a bounded hold window, so bursts stay efficient without starving the other master.
- Tracks the RAM's fixed 1-cycle read latency and steers read data back to the correct requester with a per-master readdatavalid.
- Sits between the interconnect masters and the RAM slave port.

Parameters:
- ADDR_W, 16, word-address width of the RAM and both masters.
- DEPTH, 33000, number of implemented 32-bit words; addresses >= DEPTH are out of range.
- MAX_HOLD, 4, maximum consecutive grants to one master while the other is requesting (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address, m1_address  in  ADDR_W  word address
- m0_byteenable, m1_byteenable  in  4  byte lanes
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  32  write data
- m0_waitrequest, m1_waitrequest  out  1  stall; low means the request is accepted this cycle
- m0_readdata, m1_readdata  out  32  read data
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  4  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  32  to RAM
- mem_readdata  in  32  RAM q, valid 1 cycle after the address edge
- oor_err  out  1  sticky out-of-range flag

Behaviour:
- Request definition: reqX = mX_read | mX_write. Read and write asserted together is illegal; the write is performed and the read is ignored.
- Arbitration is combinational on the current requests and registered state:
  - Only one requester: it wins.
  - Both requesting: if last_grant holds the grant and hold_cnt < MAX_HOLD, last_grant wins again; otherwise the other master wins.
- Winner: waitrequest = 0 in the same cycle. Loser: waitrequest = 1. A non-requesting master sees waitrequest = 1.
- RAM drive in the grant cycle:
  - mem_address, mem_byteenable and mem_writedata are muxed from the winner.
  - mem_chipselect = 1 and mem_write = winner's write, unless the access is out of range.
  - With no winner: mem_chipselect = 0, mem_write = 0, other mem_ outputs hold the m0 mux values.
- Registered state, updated on the grant edge:
  - last_grant ← winner.
  - hold_cnt ← 1 on a change of owner, hold_cnt + 1 on the same owner (saturating at 15), 0 when idle.
- Read return:
  - A granted read sets rd_pend <= 1 and rd_owner <= winner.
  - In the next cycle, mX_readdatavalid = rd_pend & (rd_owner == X) and mX_readdata = mem_readdata.
  - Read latency is exactly 1 cycle. Back-to-back reads, from either master, are fully pipelined at one per cycle.
- Out of range (address >= DEPTH):
  - The transfer is still accepted (no stall).
  - Writes are suppressed: mem_chipselect = 0.
  - Reads return 32'h0 with readdatavalid asserted on schedule.
  - oor_err is set and stays set until reset.
- Read data on the non-owner port is 32'h0 whenever its readdatavalid is low.
- Reset (asynchronous, any time, including mid-read):
  - rd_pend = 0, both readdatavalid = 0, oor_err = 0, hold_cnt = 0.
  - last_grant = m1, so m0 wins the first contested cycle.
  - A read in flight when reset asserts is discarded; no readdatavalid is produced after reset releases.
- With both masters requesting continuously, the grant pattern is MAX_HOLD cycles to one master, then MAX_HOLD to the other.
- With only one master requesting, it is granted every cycle regardless of MAX_HOLD.

Decomposition:
- Shared package nios_mem_pkg:
  - MEM_DATA_W = 32, MEM_BE_W = 4, MEM_ADDR_W = 16, MEM_DEPTH = 33000.
  - Master index typedef (M0 = 0, M1 = 1).
- Natural sub-module: nios_mem_rr_pick.
  - Pure combinational winner select from req[1:0], last_grant and hold_cnt versus MAX_HOLD.
  - The top level owns all registers, the data muxes and the read-return tracking.

Test Plan:
- Single master read: m0 reads address 0x0010 (RAM holds 0xDEADBEEF) → m0_waitrequest = 0 in cycle 0; cycle 1: m0_readdatavalid = 1, m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention, MAX_HOLD = 4: both masters issue continuous writes from reset → grant order m0 ×4, m1 ×4, m0 ×4; no cycle with both waitrequests low; memory contents match every write.
- Pipelined mixed reads: m0 reads 0x0001 and m1 reads 0x0002 in alternating cycles → readdatavalid alternates m0, m1 with the correct data and 1-cycle latency, no gaps.
- Byte-enable write: m1 writes 0x11223344 with byteenable 4'b0101 to 0x0100 (prior contents 0xAAAAAAAA), then reads it back → m1_readdata = 0xAA22AA44.
- Out of range: m0 writes to address 33000, then reads 33000 → mem_chipselect = 0 both cycles; readdatavalid = 1 with data 0x0; oor_err = 1 and stays 1.
- Reset mid-read: m0 read granted, reset_n pulled low before the next edge → no m0_readdatavalid after release; first contested request goes to m0.
